// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// LEGv8 fetch/PC-update stage: fetches one instruction per PC over a req/ack bus and
// computes the next PC on retire. Optional fetch timeout enabled by FETCH_TIMEOUT_EN.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
`ifdef FETCH_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               CLK,
    input  logic               Reset,
    fetch_pc_unit_if.master    imem,
    output logic [31:0]        Instruction,
    output logic [25:0]        Imm26,
    output logic               instr_valid,
    input  logic               retire,
    input  logic [63:0]        BusImm,
    input  logic               Branch,
    input  logic               Uncondbranch,
    input  logic               ALUZero,
    output logic [63:0]        PC,
    output logic               fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        taken_c;
    logic [63:0] next_pc_c;

    // Branch target is PC plus the word offset; upper immediate bits shift out
    assign taken_c   = Uncondbranch | (Branch & ALUZero);
    assign next_pc_c = pc_q + (taken_c ? (BusImm << 2) : 64'd4);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_REQ, S_WAIT: begin
                // An ack in the limit cycle still completes the fetch
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_WAIT;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d    = next_pc_c;
                    valid_d = 1'b0;
                    state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_REQ;
        endcase
    end

    // Request drops combinationally with reset so a pending fetch is abandoned at once
    assign imem.imem_req  = ((state_q == S_REQ) || (state_q == S_WAIT)) && !Reset;
    assign imem.imem_addr = pc_q;
    assign Instruction    = instr_q;
    assign Imm26          = instr_q[25:0];
    assign instr_valid    = valid_q;
    assign PC             = pc_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err      = err_q;
`else
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: table of fetch/retire vectors with
// instruction and next-PC scoreboards, plus reset and timeout sequences.
module tb_fetch_pc_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] Instruction;
    logic [25:0] Imm26;
    logic        instr_valid;
    logic        retire;
    logic [63:0] BusImm;
    logic        Branch;
    logic        Uncondbranch;
    logic        ALUZero;
    logic [63:0] PC;
    logic        fetch_err;

    fetch_pc_unit_if imem ();

    fetch_pc_unit #(.RESET_PC(64'h0)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .imem         (imem.master),
        .Instruction  (Instruction),
        .Imm26        (Imm26),
        .instr_valid  (instr_valid),
        .retire       (retire),
        .BusImm       (BusImm),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUZero      (ALUZero),
        .PC           (PC),
        .fetch_err    (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]  rdata;
        int unsigned  delay;
        logic         br;
        logic         ub;
        logic         z;
        logic [63:0]  imm;
        logic [63:0]  exp_pc;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] instr_sb[$];
    logic [63:0] pc_sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [63:0] exp_pc;
        logic [31:0] w;
        logic [63:0] p;

        vecs[0] = '{32'h91000421, 0, 1'b0, 1'b0, 1'b0, 64'h0,                   64'h4};
        vecs[1] = '{32'h14000003, 0, 1'b0, 1'b1, 1'b0, 64'h3,                   64'h10};
        vecs[2] = '{32'hB4FFFFE0, 1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8};
        vecs[3] = '{32'h14000003, 2, 1'b0, 1'b1, 1'b0, 64'h3,                   64'h14};
        vecs[4] = '{32'h17FFFFFF, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10};
        vecs[5] = '{32'hB4FFFFE1, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h14};
        vecs[6] = '{32'h17FFFFFA, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[7] = '{32'h8B020020, 0, 1'b0, 1'b0, 1'b1, 64'h5,                   64'h0};
        vecs[8] = '{32'h14000001, 0, 1'b1, 1'b1, 1'b0, 64'h4000_0000_0000_0001, 64'h4};
        vecs[9] = '{32'hD503201F, 3, 1'b0, 1'b0, 1'b0, 64'h7,                   64'h8};

        Reset = 1'b1;
        retire = 1'b0;
        BusImm = '0;
        Branch = 1'b0;
        Uncondbranch = 1'b0;
        ALUZero = 1'b0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;

        #12;
        chk("rst_req",    64'(imem.imem_req), 64'h0);
        chk("rst_pc",     PC, 64'h0);
        chk("rst_valid",  64'(instr_valid), 64'h0);
        chk("rst_instr",  64'(Instruction), 64'h0);
        chk("rst_err",    64'(fetch_err), 64'h0);

        @(posedge CLK);
        #1;
        Reset = 1'b0;
        #1;
        chk("rel_req", 64'(imem.imem_req), 64'h1);
        exp_pc = 64'h0;

        for (int i = 0; i < 10; i++) begin
            chk("req_start", 64'(imem.imem_req), 64'h1);
            chk("addr_start", imem.imem_addr, exp_pc);
            // Stall with junk retire/branch inputs that must be ignored
            for (int d = 0; d < int'(vecs[i].delay); d++) begin
                imem.imem_ack = 1'b0;
                retire = 1'b1;
                Branch = 1'b1;
                Uncondbranch = 1'b1;
                ALUZero = 1'b1;
                BusImm = {$urandom, $urandom};
                step();
                chk("wait_req",   64'(imem.imem_req), 64'h1);
                chk("wait_addr",  imem.imem_addr, exp_pc);
                chk("wait_valid", 64'(instr_valid), 64'h0);
                chk("wait_pc",    PC, exp_pc);
            end
            retire = 1'b0;
            Branch = 1'b0;
            Uncondbranch = 1'b0;
            ALUZero = 1'b0;
            imem.imem_ack = 1'b1;
            imem.imem_rdata = vecs[i].rdata;
            instr_sb.push_back(vecs[i].rdata);
            step();
            imem.imem_ack = 1'b0;
            imem.imem_rdata = $urandom;

            chk("cap_valid", 64'(instr_valid), 64'h1);
            chk("hold_req",  64'(imem.imem_req), 64'h0);
            chk("hold_pc",   PC, exp_pc);
            if (instr_valid && instr_sb.size() > 0) begin
                w = instr_sb.pop_front();
                chk("instr", 64'(Instruction), 64'(w));
                chk("imm26", 64'(Imm26), 64'(w[25:0]));
            end

            // Ack during HOLD must not overwrite the held instruction
            imem.imem_ack = 1'b1;
            imem.imem_rdata = ~vecs[i].rdata;
            step();
            imem.imem_ack = 1'b0;
            chk("hold_instr", 64'(Instruction), 64'(vecs[i].rdata));
            chk("hold_valid", 64'(instr_valid), 64'h1);

            retire = 1'b1;
            Branch = vecs[i].br;
            Uncondbranch = vecs[i].ub;
            ALUZero = vecs[i].z;
            BusImm = vecs[i].imm;
            pc_sb.push_back(vecs[i].exp_pc);
            step();
            retire = 1'b0;
            Branch = 1'b0;
            Uncondbranch = 1'b0;
            ALUZero = 1'b0;
            BusImm = '0;
            p = pc_sb.pop_front();
            chk("next_pc",     PC, p);
            chk("ret_valid",   64'(instr_valid), 64'h0);
            chk("ret_req",     64'(imem.imem_req), 64'h1);
            chk("ret_addr",    imem.imem_addr, p);
            exp_pc = p;
        end
        chk("sb_empty", 64'(instr_sb.size()), 64'h0);

        // Reset asserted mid-WAIT abandons the fetch immediately
        imem.imem_ack = 1'b0;
        step();
        step();
        chk("mid_wait_req", 64'(imem.imem_req), 64'h1);
        #3;
        Reset = 1'b1;
        #1;
        chk("mid_rst_req",   64'(imem.imem_req), 64'h0);
        chk("mid_rst_pc",    PC, 64'h0);
        chk("mid_rst_valid", 64'(instr_valid), 64'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        #1;
        chk("post_rst_req",  64'(imem.imem_req), 64'h1);
        chk("post_rst_addr", imem.imem_addr, 64'h0);

`ifdef FETCH_TIMEOUT_EN
        for (int c = 0; c < 15; c++) step();
        chk("to15_err", 64'(fetch_err), 64'h0);
        chk("to15_req", 64'(imem.imem_req), 64'h1);
        step();
        chk("to16_err",   64'(fetch_err), 64'h1);
        chk("to16_req",   64'(imem.imem_req), 64'h0);
        chk("to16_valid", 64'(instr_valid), 64'h0);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'h12345678;
        retire = 1'b1;
        step();
        step();
        imem.imem_ack = 1'b0;
        retire = 1'b0;
        chk("err_hold_err",   64'(fetch_err), 64'h1);
        chk("err_hold_req",   64'(imem.imem_req), 64'h0);
        chk("err_hold_valid", 64'(instr_valid), 64'h0);
        #3;
        Reset = 1'b1;
        #1;
        chk("err_rst_err", 64'(fetch_err), 64'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        #1;
        chk("err_rel_req", 64'(imem.imem_req), 64'h1);
        step();
        for (int c = 0; c < 14; c++) step();
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'hCAFE0042;
        step();
        imem.imem_ack = 1'b0;
        chk("to_late_valid", 64'(instr_valid), 64'h1);
        chk("to_late_instr", 64'(Instruction), 64'hCAFE0042);
        chk("to_late_err",   64'(fetch_err), 64'h0);
`else
        imem.imem_ack = 1'b0;
        for (int c = 0; c < 40; c++) step();
        chk("no_to_err", 64'(fetch_err), 64'h0);
        chk("no_to_req", 64'(imem.imem_req), 64'h1);
        imem.imem_ack = 1'b1;
        imem.imem_rdata = 32'hCAFE0042;
        step();
        imem.imem_ack = 1'b0;
        chk("late_valid", 64'(instr_valid), 64'h1);
        chk("late_instr", 64'(Instruction), 64'hCAFE0042);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
